// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback, MDU and register-file write bundle.
// master drives requests; slave (arbiter) drives the port, stall and busy.
interface regfile_write_arbiter_if #(
  parameter int REG_COUNT = 32
);
  logic                 wb_write;
  logic [4:0]           wb_addr;
  logic [31:0]          wb_data;
  logic                 mdu_issue;
  logic [4:0]           mdu_issue_addr;
  logic                 mdu_valid;
  logic [4:0]           mdu_addr;
  logic [31:0]          mdu_data;
  logic                 mdu_ready;
  logic                 rf_write;
  logic [4:0]           rf_addr;
  logic [31:0]          rf_data;
  logic                 stall_req;
  logic [REG_COUNT-1:0] busy_vector;

  modport master (
    output wb_write, wb_addr, wb_data,
    output mdu_issue, mdu_issue_addr,
    output mdu_valid, mdu_addr, mdu_data,
    input  mdu_ready,
    input  rf_write, rf_addr, rf_data,
    input  stall_req, busy_vector
  );

  modport slave (
    input  wb_write, wb_addr, wb_data,
    input  mdu_issue, mdu_issue_addr,
    input  mdu_valid, mdu_addr, mdu_data,
    output mdu_ready,
    output rf_write, rf_addr, rf_data,
    output stall_req, busy_vector
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the RF write port between writeback and MDU.
// Ports: clk, rst (sync, active high), bus (slave modport). Macro: REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int REG_COUNT = 32,
  parameter int MAX_WAIT  = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_e               state_q, state_d;
  logic [4:0]           buf_addr_q, buf_addr_d;
  logic [31:0]          buf_data_q, buf_data_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 stall_req_q, stall_req_d;
  logic [REG_COUNT-1:0] busy_q, busy_d;

  logic wb_eff;
  logic buf_valid;
  logic buf_drain;
  logic byp;
  logic mdu_ready;
  logic xfer;
  logic load;
  logic sel_wb;
  logic sel_buf;
  logic sel_byp;

  logic                 rf_write;
  logic [4:0]           rf_addr;
  logic [31:0]          rf_data;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  assign wb_eff    = bus.wb_write && (bus.wb_addr != 5'd0);
  assign buf_valid = (state_q != EMPTY);
  assign buf_drain = buf_valid && !wb_eff;

`ifdef REGFILE_ARB_BYPASS_EN
  // Idle port and empty buffer: write the MDU result straight through.
  assign byp = !rst && !wb_eff && !buf_valid && bus.mdu_valid;
`else
  assign byp = 1'b0;
`endif

  assign mdu_ready = !rst && (!buf_valid || buf_drain);
  assign xfer      = bus.mdu_valid && mdu_ready;
  assign load      = xfer && !byp;

  assign sel_wb  = !rst && wb_eff;
  assign sel_buf = !rst && buf_drain;
  assign sel_byp = byp;

  always_comb begin
    rf_write = 1'b0;
    rf_addr  = 5'd0;
    rf_data  = 32'd0;
    unique case (1'b1)
      sel_wb: begin
        rf_write = 1'b1;
        rf_addr  = bus.wb_addr;
        rf_data  = bus.wb_data;
      end
      sel_buf: begin
        rf_write = (buf_addr_q != 5'd0);
        rf_addr  = buf_addr_q;
        rf_data  = buf_data_q;
      end
      sel_byp: begin
        rf_write = (bus.mdu_addr != 5'd0);
        rf_addr  = bus.mdu_addr;
        rf_data  = bus.mdu_data;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    wait_cnt_d = wait_cnt_q;
    if (load) begin
      buf_addr_d = bus.mdu_addr;
      buf_data_d = bus.mdu_data;
    end
    unique case (state_q)
      EMPTY: begin
        if (load) begin
          state_d    = HOLD;
          wait_cnt_d = 4'd0;
        end
      end
      HOLD, FORCE: begin
        if (buf_drain) begin
          state_d    = load ? HOLD : EMPTY;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          // Starved: stay here until writeback backs off.
          state_d = FORCE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    stall_req_d = (state_d == FORCE);
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (sel_buf) begin
      clr_mask[buf_addr_q] = 1'b1;
    end
    if (sel_byp) begin
      clr_mask[bus.mdu_addr] = 1'b1;
    end
    if (bus.mdu_issue && (bus.mdu_issue_addr != 5'd0)) begin
      set_mask[bus.mdu_issue_addr] = 1'b1;
    end
    // A new issue to a register retiring this cycle keeps it busy.
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      buf_addr_q  <= 5'd0;
      buf_data_q  <= 32'd0;
      wait_cnt_q  <= 4'd0;
      stall_req_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_req_q <= stall_req_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mdu_ready   = mdu_ready;
  assign bus.rf_write    = rf_write;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_data     = rf_data;
  assign bus.stall_req   = stall_req_q;
  assign bus.busy_vector = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed bench for regfile_write_arbiter.
// MDU results queue in a scoreboard and are popped as they reach the RF port.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

`ifdef REGFILE_ARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.REG_COUNT(32)) bus ();

  regfile_write_arbiter #(
    .REG_COUNT(32),
    .MAX_WAIT (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (bus.wb_write && bus.wb_addr != 5'd0) begin
      chk("wb_we", 32'(bus.rf_write), 32'd1);
      chk("wb_addr", 32'(bus.rf_addr), 32'(bus.wb_addr));
      chk("wb_data", bus.rf_data, bus.wb_data);
    end else if (bus.rf_write) begin
      if (sb.size() == 0) begin
        chk("spurious_wr", 32'(bus.rf_write), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("mdu_addr", 32'(bus.rf_addr), 32'(e.a));
        chk("mdu_data", bus.rf_data, e.d);
      end
    end
  endtask

  task automatic nedge();
    @(negedge clk);
    mon();
  endtask

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_write       = 1'b0;
    bus.wb_addr        = 5'd0;
    bus.wb_data        = 32'd0;
    bus.mdu_issue      = 1'b0;
    bus.mdu_issue_addr = 5'd0;
    bus.mdu_valid      = 1'b0;
    bus.mdu_addr       = 5'd0;
    bus.mdu_data       = 32'd0;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1;
    bus.mdu_addr  = a;
    bus.mdu_data  = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_write = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    pedge();
    pedge();
    nedge();
    chk("rst_ready", 32'(bus.mdu_ready), 32'd0);
    chk("rst_we", 32'(bus.rf_write), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_busy", bus.busy_vector, 32'd0);
    pedge();
    rst = 1'b0;

    // free port
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd7;
    nedge();
    pedge();
    bus.mdu_issue = 1'b0;
    mdu(5'd7, 32'hDEADBEEF);
    sb.push_back('{a: 5'd7, d: 32'hDEADBEEF});
    nedge();
    chk("fp_busy_set", 32'(bus.busy_vector[7]), 32'd1);
    chk("fp_ready", 32'(bus.mdu_ready), 32'd1);
    chk("fp_we_t0", 32'(bus.rf_write), 32'(BYP));
    pedge();
    bus.mdu_valid = 1'b0;
    nedge();
    chk("fp_we_t1", 32'(bus.rf_write), 32'(!BYP));
    chk("fp_busy_t1", 32'(bus.busy_vector[7]), 32'(!BYP));
    pedge();
    nedge();
    chk("fp_busy_clr", 32'(bus.busy_vector[7]), 32'd0);
    chk("fp_sb_empty", 32'(sb.size()), 32'd0);
    pedge();

    // reset while holding
    wb(5'd10, 32'h1010);
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd5;
    nedge();
    pedge();
    bus.mdu_issue = 1'b0;
    mdu(5'd5, 32'h55);
    nedge();
    chk("rh_ready_empty", 32'(bus.mdu_ready), 32'd1);
    pedge();
    bus.mdu_valid = 1'b0;
    nedge();
    chk("rh_ready_full", 32'(bus.mdu_ready), 32'd0);
    chk("rh_busy5", 32'(bus.busy_vector[5]), 32'd1);
    pedge();
    bus.wb_write = 1'b0;
    rst = 1'b1;
    nedge();
    chk("rh_in_rst_we", 32'(bus.rf_write), 32'd0);
    chk("rh_in_rst_rdy", 32'(bus.mdu_ready), 32'd0);
    pedge();
    rst = 1'b0;
    nedge();
    chk("rh_busy", bus.busy_vector, 32'd0);
    chk("rh_stall", 32'(bus.stall_req), 32'd0);
    chk("rh_ready", 32'(bus.mdu_ready), 32'd1);
    chk("rh_we", 32'(bus.rf_write), 32'd0);
    pedge();

    // contention and forced stall
    wb(5'd9, 32'h99);
    mdu(5'd3, 32'h33);
    sb.push_back('{a: 5'd3, d: 32'h33});
    nedge();
    chk("ct_ready0", 32'(bus.mdu_ready), 32'd1);
    pedge();
    bus.mdu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nedge();
      chk("ct_no_stall", 32'(bus.stall_req), 32'd0);
      chk("ct_blocked", 32'(bus.mdu_ready), 32'd0);
      pedge();
    end
    nedge();
    chk("ct_stall", 32'(bus.stall_req), 32'd1);
    pedge();
    nedge();
    chk("ct_stall_hold", 32'(bus.stall_req), 32'd1);
    pedge();
    bus.wb_write = 1'b0;
    nedge();
    chk("ct_drain_rdy", 32'(bus.mdu_ready), 32'd1);
    chk("ct_drain_stall", 32'(bus.stall_req), 32'd1);
    pedge();
    nedge();
    chk("ct_stall_clr", 32'(bus.stall_req), 32'd0);
    chk("ct_sb_empty", 32'(sb.size()), 32'd0);
    pedge();

    // back-to-back
    for (int i = 0; i < 4; i++) begin
      bus.mdu_valid = (i < 3);
      bus.mdu_addr  = 5'(i + 1);
      bus.mdu_data  = 32'h100 + 32'(i + 1);
      if (i < 3) begin
        sb.push_back('{a: 5'(i + 1), d: 32'h100 + 32'(i + 1)});
      end
      nedge();
      if (i < 3) begin
        chk("bb_ready", 32'(bus.mdu_ready), 32'd1);
      end
      chk("bb_we", 32'(bus.rf_write),
          32'(BYP ? (i < 3) : (i > 0)));
      pedge();
    end
    chk("bb_sb_empty", 32'(sb.size()), 32'd0);

    // zero register
    idle();
    wb(5'd11, 32'h1111);
    mdu(5'd4, 32'h44);
    sb.push_back('{a: 5'd4, d: 32'h44});
    nedge();
    pedge();
    bus.mdu_valid = 1'b0;
    wb(5'd0, 32'hBAD);
    nedge();
    chk("zr_wb0_we", 32'(bus.rf_write), 32'd1);
    chk("zr_wb0_addr", 32'(bus.rf_addr), 32'd4);
    pedge();
    bus.wb_write = 1'b0;
    mdu(5'd0, 32'h77);
    nedge();
    chk("zr_m0_we0", 32'(bus.rf_write), 32'd0);
    chk("zr_m0_rdy0", 32'(bus.mdu_ready), 32'd1);
    pedge();
    bus.mdu_valid = 1'b0;
    nedge();
    chk("zr_m0_we1", 32'(bus.rf_write), 32'd0);
    chk("zr_m0_rdy1", 32'(bus.mdu_ready), 32'd1);
    pedge();
    wb(5'd13, 32'h1313);
    nedge();
    chk("zr_m0_empty", 32'(bus.mdu_ready), 32'd1);
    pedge();

    // scoreboard race
    idle();
    bus.mdu_issue      = 1'b1;
    bus.mdu_issue_addr = 5'd6;
    wb(5'd12, 32'h1212);
    mdu(5'd6, 32'h66);
    sb.push_back('{a: 5'd6, d: 32'h66});
    nedge();
    pedge();
    bus.mdu_valid = 1'b0;
    bus.wb_write  = 1'b0;
    nedge();
    pedge();
    bus.mdu_issue = 1'b0;
    nedge();
    chk("race_busy6", 32'(bus.busy_vector[6]), 32'd1);
    chk("race_busy", bus.busy_vector, 32'h40);
    pedge();

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
